ahb_copy_dma: RTL
=================

AHB_COPY_DMA -- requirements
Module: ahb_copy_dma

Interface
REQ-001 SHALL have parameter LEN_W, default 16: width of the word-count input.
REQ-002 SHALL have port hclk, input, 1: AHB clock; all logic on rising edge.
REQ-003 SHALL have port hresetn, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: one-cycle request to begin a copy.
REQ-005 SHALL have port src_addr, input, 32: source byte address; bits [1:0] ignored.
REQ-006 SHALL have port dst_addr, input, 32: destination byte address; bits [1:0] ignored.
REQ-007 SHALL have port len, input, LEN_W: number of 32-bit words to copy.
REQ-008 SHALL have port busy, output, 1: copy in progress.
REQ-009 SHALL have port done, output, 1: one-cycle pulse at end of copy or abort.
REQ-010 SHALL have port error, output, 1: sticky, last copy aborted on ERROR response.
REQ-011 SHALL have AHB-Lite master outputs haddr 32, htrans 2, hwrite 1, hsize 3, hburst 3, hprot 4, hwdata 32.
REQ-012 SHALL have AHB-Lite master inputs hready 1, hresp 1 (0=OKAY, 1=ERROR), hrdata 32.

Function
REQ-013 SHALL drive hsize=3'b010, hburst=3'b000 (SINGLE), hprot=4'b0011 constantly.
REQ-014 SHALL implement states IDLE, RD_A, RD_D, WR_A, WR_D.
REQ-015 IDLE: htrans=IDLE; start=1 latches src/dst (bits [1:0] forced 0) and len; len!=0 -> RD_A, busy=1; len=0 -> stay IDLE, done pulse next cycle, no bus transfer.
REQ-016 RD_A: htrans=NONSEQ, hwrite=0, haddr=current src; held stable until hready=1, then -> RD_D.
REQ-017 RD_D: htrans=IDLE; on hready=1 & hresp=0 capture hrdata into 32-bit buffer, -> WR_A.
REQ-018 WR_A: htrans=NONSEQ, hwrite=1, haddr=current dst; held until hready=1, then -> WR_D.
REQ-019 WR_D: htrans=IDLE, hwdata=buffer held stable; on hready=1 & hresp=0: src+=4, dst+=4, count-=1; count reaching 0 -> IDLE with done pulse, busy=0; else -> RD_A.
REQ-020 Address increment SHALL wrap modulo 2^32 with no error.
REQ-021 hresp=1 & hready=1 in RD_D or WR_D SHALL abort: -> IDLE, error=1, done pulse, busy=0; no further transfer issued; ERROR first cycle (hready=0) already sees htrans=IDLE.
REQ-022 start while busy=1 SHALL be ignored; start in IDLE SHALL clear error.
REQ-023 Only one transfer outstanding: never NONSEQ in the same cycle as a pending data phase.
REQ-024 done and busy SHALL never both be 1 in the same cycle.
REQ-025 Per word, zero-wait-state bus: exactly 4 cycles (RD_A, RD_D, WR_A, WR_D).

Reset
REQ-026 hresetn=0 SHALL immediately force IDLE, htrans=00, hwrite=0, haddr=0, hwdata=0, buffer=0, count=0, busy=0, done=0, error=0.
REQ-027 Reset mid-copy SHALL abandon the transfer without a done pulse; after release, block idles until next start.

Verification
REQ-028 Zero-wait slave, src=0x100, dst=0x200, len=4, mem[0x100..0x10C]=1,2,3,4 -> dst words=1,2,3,4; done at cycle 16 after start; busy high 16 cycles.
REQ-029 Slave inserts 1 wait on every read data phase, len=2 -> 10 cycles; haddr/htrans stable while hready=0; data correct.
REQ-030 len=0 -> no NONSEQ ever; done pulse one cycle after start; error=0.
REQ-031 ERROR on 2nd write (two-cycle response) -> error=1, done pulse, only word 1 written, htrans=IDLE thereafter.
REQ-032 src=0xFFFFFFFC, len=2, plus start re-asserted while busy -> 2nd read at 0x00000000; re-start ignored; single done pulse.
REQ-033 hresetn asserted during WR_D of word 3 -> all outputs reset immediately; no done; subsequent len=1 copy succeeds.

Source files
------------

// File: rtl/ahb_copy_dma_if.sv
// AHB-Lite bus bundle between the copy engine (master) and the system fabric (slave).
interface ahb_copy_dma_if;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/ahb_copy_dma.sv
// Word-by-word memory copy engine on an AHB-Lite master port.
// One SINGLE read followed by one SINGLE write per word; never more than
// one transfer outstanding. An ERROR response aborts the copy.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no copy running; waits for start
// RD_A   | read address phase (NONSEQ, hwrite=0) at current source
// RD_D   | read data phase; captures hrdata into the word buffer
// WR_A   | write address phase (NONSEQ, hwrite=1) at current destination
// WR_D   | write data phase; drives buffer on hwdata, advances pointers
module ahb_copy_dma #(
    parameter int LEN_W = 16
) (
    input  logic             hclk,
    input  logic             hresetn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             error,
    ahb_copy_dma_if.master   ahb
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_D,
        S_WR_A,
        S_WR_D
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [31:0]      buf_q, buf_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic [31:0]      haddr_c;
    logic [1:0]       htrans_c;
    logic             hwrite_c;

    // Byte-lane bits of the start addresses are dropped; transfers are word aligned.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

    // State, pointers, counter, buffer and status flags.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            buf_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Next-state logic and bus address-phase outputs.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        count_d  = count_q;
        buf_d    = buf_q;
        done_d   = 1'b0;
        error_d  = error_q;
        haddr_c  = 32'h0;
        htrans_c = HTRANS_IDLE;
        hwrite_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    src_d   = {src_addr[31:2], 2'b00};
                    dst_d   = {dst_addr[31:2], 2'b00};
                    count_d = len;
                    if (len != '0) begin
                        state_d = S_RD_A;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RD_A: begin
                htrans_c = HTRANS_NONSEQ;
                haddr_c  = src_q;
                if (ahb.hready) begin
                    state_d = S_RD_D;
                end
            end
            S_RD_D: begin
                haddr_c = src_q;
                if (ahb.hready) begin
                    if (ahb.hresp) begin
                        state_d = S_IDLE;
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        buf_d   = ahb.hrdata;
                        state_d = S_WR_A;
                    end
                end
            end
            S_WR_A: begin
                htrans_c = HTRANS_NONSEQ;
                hwrite_c = 1'b1;
                haddr_c  = dst_q;
                if (ahb.hready) begin
                    state_d = S_WR_D;
                end
            end
            S_WR_D: begin
                haddr_c = dst_q;
                if (ahb.hready) begin
                    if (ahb.hresp) begin
                        state_d = S_IDLE;
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        // Pointers wrap naturally at 2^32.
                        src_d   = src_q + 32'd4;
                        dst_d   = dst_q + 32'd4;
                        count_d = count_q - LEN_W'(1);
                        if (count_q == LEN_W'(1)) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_RD_A;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ahb.haddr  = haddr_c;
    assign ahb.htrans = htrans_c;
    assign ahb.hwrite = hwrite_c;
    assign ahb.hsize  = 3'b010;
    assign ahb.hburst = 3'b000;
    assign ahb.hprot  = 4'b0011;
    assign ahb.hwdata = buf_q;

    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign error = error_q;

endmodule
